// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake engine: direction codes, FSM encoding,
// reversal test and cell-index <-> (row, col) conversion.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_L = 2'b00,
      DIR_R = 2'b01,
      DIR_U = 2'b10,
      DIR_D = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DEAD = 2'b10
   } state_t;

   // Left/right and up/down differ only in bit 0.
   function automatic dir_t opposite(dir_t d);
      return dir_t'(d ^ 2'b01);
   endfunction

   function automatic logic [31:0] pos_row(logic [31:0] pos, logic [31:0] width);
      return pos / width;
   endfunction

   function automatic logic [31:0] pos_col(logic [31:0] pos, logic [31:0] width);
      return pos % width;
   endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Control inputs and board-state outputs of the snake engine, bundled for the
// direction decoder (master) and the engine itself (slave).
interface snake_engine_if #(
   parameter int MAX_LEN = 16,
   parameter int POS_W   = 10,
   parameter int LEN_W   = 5
);
   logic                     start;
   logic                     tick;
   logic [1:0]               dir_in;
   logic                     dir_valid;
   logic                     grow;
   logic [MAX_LEN*POS_W-1:0] body;
   logic [LEN_W-1:0]         len;
   logic [POS_W-1:0]         head;
   logic                     alive;
   logic                     dead;
   logic                     step_done;

   modport master (
      output start, tick, dir_in, dir_valid, grow,
      input  body, len, head, alive, dead, step_done
   );

   modport slave (
      input  start, tick, dir_in, dir_valid, grow,
      output body, len, head, alive, dead, step_done
   );
endinterface

// File: rtl/snake_next_head.sv
// Combinational neighbour of a cell in a given direction, flagging when the
// move crosses the playfield edge (and wrapping the index when WRAP is set).
module snake_next_head
   import snake_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 24,
   parameter int POS_W  = 10,
   parameter int WRAP   = 0
) (
   input  logic [POS_W-1:0] pos,
   input  dir_t             dir,
   output logic [POS_W-1:0] nh,
   output logic             wall_hit
);

   localparam logic [POS_W-1:0] ONE      = POS_W'(1);
   localparam logic [POS_W-1:0] ROW_STEP = POS_W'(WIDTH);
   localparam logic [POS_W-1:0] COL_SPAN = POS_W'(WIDTH - 1);
   localparam logic [POS_W-1:0] ROW_SPAN = POS_W'((HEIGHT - 1) * WIDTH);

   logic [31:0] row;
   logic [31:0] col;

   always_comb begin
      row      = pos_row(32'(pos), WIDTH);
      col      = pos_col(32'(pos), WIDTH);
      nh       = pos;
      wall_hit = 1'b0;
      // With WRAP=0 the value of nh on a wall hit is irrelevant: the step dies.
      unique case (dir)
         DIR_L: begin
            wall_hit = (col == 0);
            nh = wall_hit ? ((WRAP != 0) ? pos + COL_SPAN : pos) : pos - ONE;
         end
         DIR_R: begin
            wall_hit = (col == WIDTH - 1);
            nh = wall_hit ? ((WRAP != 0) ? pos - COL_SPAN : pos) : pos + ONE;
         end
         DIR_U: begin
            wall_hit = (row == 0);
            nh = wall_hit ? ((WRAP != 0) ? pos + ROW_SPAN : pos) : pos - ROW_STEP;
         end
         DIR_D: begin
            wall_hit = (row == HEIGHT - 1);
            nh = wall_hit ? ((WRAP != 0) ? pos - ROW_SPAN : pos) : pos + ROW_STEP;
         end
      endcase
   end

endmodule

// File: rtl/snake_engine.sv
// Snake game state machine: body shift register, length, heading, growth and
// life/death, advancing one cell per tick strobe.
module snake_engine
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = 16,
   parameter int WIDTH    = 32,
   parameter int HEIGHT   = 24,
   parameter int POS_W    = 10,
   parameter int LEN_W    = 5,
   parameter int INIT_POS = 100,
   parameter int INIT_LEN = 3,
   parameter int WRAP     = 0
) (
   input logic           clk,
   input logic           rst_n,
   snake_engine_if.slave bus
);

   state_t           state_q, state_d;
   dir_t             cur_dir_q, cur_dir_d;
   dir_t             pend_dir_q, pend_dir_d;
   logic             grow_pend_q, grow_pend_d;
   logic [POS_W-1:0] body_q [MAX_LEN];
   logic [POS_W-1:0] body_d [MAX_LEN];
   logic [LEN_W-1:0] len_q, len_d;
   logic             step_done_q, step_d;
   logic             alive_q, dead_q;

   dir_t             eff_dir;
   logic             dir_accept;
   logic [POS_W-1:0] nh;
   logic             wall_hit;
   logic             g;
   logic [LEN_W-1:0] cmp_lim;
   logic             self_hit;
   logic             collide;

   function automatic logic [POS_W-1:0] init_slot(int i);
      return (i < INIT_LEN) ? POS_W'(INIT_POS - i) : '0;
   endfunction

   snake_next_head #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .POS_W  (POS_W),
      .WRAP   (WRAP)
   ) u_next_head (
      .pos      (body_q[0]),
      .dir      (eff_dir),
      .nh       (nh),
      .wall_hit (wall_hit)
   );

   // A request in the tick cycle steers that very step.
   assign dir_accept = bus.dir_valid && (dir_t'(bus.dir_in) != opposite(cur_dir_q));
   assign eff_dir    = dir_accept ? dir_t'(bus.dir_in) : pend_dir_q;
   assign g          = (grow_pend_q | bus.grow) && (len_q < LEN_W'(MAX_LEN));
   assign cmp_lim    = g ? len_q : len_q - LEN_W'(1);

   always_comb begin
      self_hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
         if ((LEN_W'(i) < cmp_lim) && (body_q[i] == nh))
            self_hit = 1'b1;
   end

   assign collide = ((WRAP == 0) && wall_hit) || self_hit;

   always_comb begin
      // NOTE: every signal written here is defaulted first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      cur_dir_d   = cur_dir_q;
      pend_dir_d  = pend_dir_q;
      grow_pend_d = grow_pend_q | bus.grow;
      body_d      = body_q;
      len_d       = len_q;
      step_d      = 1'b0;
      if (dir_accept)
         pend_dir_d = dir_t'(bus.dir_in);

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.tick) begin
               step_d      = 1'b1;
               cur_dir_d   = eff_dir;
               grow_pend_d = 1'b0;
               if (collide) begin
                  state_d = ST_DEAD;
               end else begin
                  for (int i = 1; i < MAX_LEN; i++)
                     body_d[i] = body_q[i-1];
                  body_d[0] = nh;
                  len_d     = len_q + LEN_W'(g);
               end
            end
         end
         ST_DEAD: begin
            if (bus.start) begin
               state_d     = ST_RUN;
               cur_dir_d   = DIR_R;
               pend_dir_d  = DIR_R;
               grow_pend_d = 1'b0;
               len_d       = LEN_W'(INIT_LEN);
               for (int i = 0; i < MAX_LEN; i++)
                  body_d[i] = init_slot(i);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: registers take non-blocking assignments so every flop samples the
   // pre-edge values; blocking here would let the shift register collapse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cur_dir_q   <= DIR_R;
         pend_dir_q  <= DIR_R;
         grow_pend_q <= 1'b0;
         len_q       <= LEN_W'(INIT_LEN);
         step_done_q <= 1'b0;
         alive_q     <= 1'b0;
         dead_q      <= 1'b0;
         // NOTE: the body array is reset on purpose: the start layout is
         // visible game state, not scratch storage.
         for (int i = 0; i < MAX_LEN; i++)
            body_q[i] <= init_slot(i);
      end else begin
         state_q     <= state_d;
         cur_dir_q   <= cur_dir_d;
         pend_dir_q  <= pend_dir_d;
         grow_pend_q <= grow_pend_d;
         len_q       <= len_d;
         step_done_q <= step_d;
         alive_q     <= (state_d == ST_RUN);
         dead_q      <= (state_d == ST_DEAD);
         for (int i = 0; i < MAX_LEN; i++)
            body_q[i] <= body_d[i];
      end
   end

   for (genvar i = 0; i < MAX_LEN; i++) begin : g_body
      assign bus.body[i*POS_W +: POS_W] = body_q[i];
   end

   assign bus.head      = body_q[0];
   assign bus.len       = len_q;
   assign bus.alive     = alive_q;
   assign bus.dead      = dead_q;
   assign bus.step_done = step_done_q;

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: a walled and a wrapping instance share one
// stimulus stream; each step_done pops and compares a hand-computed snapshot.
module tb_snake_engine;
   import snake_pkg::*;

   localparam int MAX_LEN = 16;
   localparam int POS_W   = 10;
   localparam int LEN_W   = 5;

   typedef struct {
      string tag;
      int    len;
      int    alive;
      int    dead;
      int    n;
      int    s0;
      int    s1;
      int    s2;
      int    s3;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       tick = 1'b0;
   logic       dir_valid = 1'b0;
   logic       grow = 1'b0;
   logic [1:0] dir_in = 2'b00;

   int   total = 0;
   int   bad = 0;
   exp_t q_wall[$];
   exp_t q_wrap[$];

   always #5 clk = ~clk;

   snake_engine_if #(.MAX_LEN(MAX_LEN), .POS_W(POS_W), .LEN_W(LEN_W)) bus_wall ();
   snake_engine_if #(.MAX_LEN(MAX_LEN), .POS_W(POS_W), .LEN_W(LEN_W)) bus_wrap ();

   assign bus_wall.start     = start;
   assign bus_wall.tick      = tick;
   assign bus_wall.dir_in    = dir_in;
   assign bus_wall.dir_valid = dir_valid;
   assign bus_wall.grow      = grow;
   assign bus_wrap.start     = start;
   assign bus_wrap.tick      = tick;
   assign bus_wrap.dir_in    = dir_in;
   assign bus_wrap.dir_valid = dir_valid;
   assign bus_wrap.grow      = grow;

   snake_engine #(.MAX_LEN(MAX_LEN), .WIDTH(32), .HEIGHT(24), .POS_W(POS_W), .LEN_W(LEN_W),
                  .INIT_POS(100), .INIT_LEN(3), .WRAP(0))
      u_wall (.clk(clk), .rst_n(rst_n), .bus(bus_wall));

   snake_engine #(.MAX_LEN(MAX_LEN), .WIDTH(32), .HEIGHT(24), .POS_W(POS_W), .LEN_W(LEN_W),
                  .INIT_POS(100), .INIT_LEN(3), .WRAP(1))
      u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_wrap));

   task automatic check(string name, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(string tag, int len, int alive, int dead, int n,
                               int s0, int s1, int s2, int s3);
      exp_t e;
      e.tag = tag; e.len = len; e.alive = alive; e.dead = dead; e.n = n;
      e.s0 = s0; e.s1 = s1; e.s2 = s2; e.s3 = s3;
      return e;
   endfunction

   function automatic int slot(logic [MAX_LEN*POS_W-1:0] body, int i);
      return int'(body[i*POS_W +: POS_W]);
   endfunction

   task automatic compare_step(string who, exp_t e, logic [MAX_LEN*POS_W-1:0] body,
                               int len, int head, int alive, int dead);
      int want [4];
      want[0] = e.s0; want[1] = e.s1; want[2] = e.s2; want[3] = e.s3;
      check({who, ".", e.tag, ".head"}, head, e.s0);
      check({who, ".", e.tag, ".len"}, len, e.len);
      check({who, ".", e.tag, ".alive"}, alive, e.alive);
      check({who, ".", e.tag, ".dead"}, dead, e.dead);
      for (int i = 0; i < e.n; i++)
         check($sformatf("%s.%s.slot%0d", who, e.tag, i), slot(body, i), want[i]);
   endtask

   // Scoreboard monitors: one per instance, triggered by step_done.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus_wall.step_done) begin
         if (q_wall.size() == 0) begin
            total++; bad++;
            $display("FAIL wall.unexpected_step: got step_done=1, expected 0");
         end else begin
            e = q_wall.pop_front();
            compare_step("wall", e, bus_wall.body, int'(bus_wall.len), int'(bus_wall.head),
                         int'(bus_wall.alive), int'(bus_wall.dead));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus_wrap.step_done) begin
         if (q_wrap.size() == 0) begin
            total++; bad++;
            $display("FAIL wrap.unexpected_step: got step_done=1, expected 0");
         end else begin
            e = q_wrap.pop_front();
            compare_step("wrap", e, bus_wrap.body, int'(bus_wrap.len), int'(bus_wrap.head),
                         int'(bus_wrap.alive), int'(bus_wrap.dead));
         end
      end
   end

   task automatic push_both(exp_t e);
      q_wall.push_back(e);
      q_wrap.push_back(e);
   endtask

   task automatic idle_inputs();
      start = 1'b0; tick = 1'b0; dir_valid = 1'b0; dir_in = 2'b00; grow = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one cycle of inputs, then return to idle on the next falling edge.
   task automatic pulse(logic s, logic t, logic dv, logic [1:0] d, logic gr);
      start = s; tick = t; dir_valid = dv; dir_in = d; grow = gr;
      @(negedge clk);
      idle_inputs();
   endtask

   // Bounded wait for the scoreboard; leftovers count as missed steps.
   task automatic drain(string tag);
      for (int c = 0; c < 4 && (q_wall.size() != 0 || q_wrap.size() != 0); c++)
         @(negedge clk);
      @(negedge clk);
      check({tag, ".wall_pending"}, q_wall.size(), 0);
      check({tag, ".wrap_pending"}, q_wrap.size(), 0);
   endtask

   task automatic check_layout(string tag);
      check({tag, ".len"}, int'(bus_wall.len), 3);
      check({tag, ".head"}, int'(bus_wall.head), 100);
      check({tag, ".slot1"}, slot(bus_wall.body, 1), 99);
      check({tag, ".slot2"}, slot(bus_wall.body, 2), 98);
      check({tag, ".alive"}, int'(bus_wall.alive), 0);
      check({tag, ".dead"}, int'(bus_wall.dead), 0);
      check({tag, ".step_done"}, int'(bus_wall.step_done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset layout, then start+tick together in IDLE: start only, no step.
      check_layout("reset");
      check("reset.slot3_zero", slot(bus_wall.body, 3), 0);
      pulse(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
      check("start.alive", int'(bus_wall.alive), 1);
      check("start.head_no_step", int'(bus_wall.head), 100);

      // First step right; step_done must drop the following cycle.
      push_both(mk("t1", 3, 1, 0, 3, 101, 100, 99, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      check("t1.step_done_one_cycle", int'(bus_wall.step_done), 0);

      // Reversal rejected, then down accepted.
      pulse(1'b0, 1'b0, 1'b1, DIR_L, 1'b0);
      push_both(mk("t2_rev", 3, 1, 0, 3, 102, 101, 100, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      pulse(1'b0, 1'b0, 1'b1, DIR_D, 1'b0);
      push_both(mk("t2_down", 3, 1, 0, 3, 134, 102, 101, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      drain("t2");

      // Growth up to MAX_LEN, then a saturating grow.
      do_reset();
      pulse(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      pulse(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      push_both(mk("g4", 4, 1, 0, 4, 101, 100, 99, 98));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      for (int k = 5; k <= 16; k++) begin
         push_both(mk($sformatf("g%0d", k), k, 1, 0, 4, 97 + k, 96 + k, 95 + k, 94 + k));
         pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      end
      check("g16.tail_slot15", slot(bus_wall.body, 15), 98);
      push_both(mk("g_sat", 16, 1, 0, 4, 114, 113, 112, 111));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      check("g_sat.tail_slot15", slot(bus_wall.body, 15), 99);
      drain("t3");

      // Up into the top wall: walled instance dies, wrapping one reappears.
      do_reset();
      pulse(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      push_both(mk("up1", 3, 1, 0, 3, 68, 100, 99, 0));
      pulse(1'b0, 1'b1, 1'b1, DIR_U, 1'b0);
      push_both(mk("up2", 3, 1, 0, 3, 36, 68, 100, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      push_both(mk("up3", 3, 1, 0, 3, 4, 36, 68, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      q_wall.push_back(mk("wall_hit", 3, 0, 1, 3, 4, 36, 68, 0));
      q_wrap.push_back(mk("wrap_up", 3, 1, 0, 3, 740, 4, 36, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      q_wrap.push_back(mk("wrap_up2", 3, 1, 0, 3, 708, 740, 4, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      check("dead.head_frozen", int'(bus_wall.head), 4);
      check("dead.flag", int'(bus_wall.dead), 1);
      pulse(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      check("restart.alive", int'(bus_wall.alive), 1);
      check("restart.dead", int'(bus_wall.dead), 0);
      check("restart.head", int'(bus_wall.head), 100);
      check("restart.len", int'(bus_wall.len), 3);
      check("restart.wrap_head_kept", int'(bus_wrap.head), 708);
      q_wall.push_back(mk("restart_step", 3, 1, 0, 3, 101, 100, 99, 0));
      q_wrap.push_back(mk("wrap_up3", 3, 1, 0, 3, 676, 708, 740, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      drain("t4");

      // Self-collision at len 5: down, left, up lands on slot 3.
      do_reset();
      pulse(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      push_both(mk("s5_g4", 4, 1, 0, 4, 101, 100, 99, 98));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      push_both(mk("s5_g5", 5, 1, 0, 4, 102, 101, 100, 99));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      push_both(mk("s5_down", 5, 1, 0, 4, 134, 102, 101, 100));
      pulse(1'b0, 1'b1, 1'b1, DIR_D, 1'b0);
      push_both(mk("s5_left", 5, 1, 0, 4, 133, 134, 102, 101));
      pulse(1'b0, 1'b1, 1'b1, DIR_L, 1'b0);
      push_both(mk("s5_bite", 5, 0, 1, 4, 133, 134, 102, 101));
      pulse(1'b0, 1'b1, 1'b1, DIR_U, 1'b0);
      drain("t5a");

      // Same path at len 4: the target is the vacating tail, no death.
      do_reset();
      pulse(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      push_both(mk("s4_g4", 4, 1, 0, 4, 101, 100, 99, 98));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
      push_both(mk("s4_r", 4, 1, 0, 4, 102, 101, 100, 99));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      push_both(mk("s4_down", 4, 1, 0, 4, 134, 102, 101, 100));
      pulse(1'b0, 1'b1, 1'b1, DIR_D, 1'b0);
      push_both(mk("s4_left", 4, 1, 0, 4, 133, 134, 102, 101));
      pulse(1'b0, 1'b1, 1'b1, DIR_L, 1'b0);
      push_both(mk("s4_tail", 4, 1, 0, 4, 101, 133, 134, 102));
      pulse(1'b0, 1'b1, 1'b1, DIR_U, 1'b0);
      drain("t5b");

      // Reset mid-run discards pending grow and direction.
      do_reset();
      pulse(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      push_both(mk("r_pre", 3, 1, 0, 3, 101, 100, 99, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      pulse(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      pulse(1'b0, 1'b0, 1'b1, DIR_D, 1'b0);
      do_reset();
      check_layout("midreset");
      pulse(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      push_both(mk("r_post", 3, 1, 0, 3, 101, 100, 99, 0));
      pulse(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
      drain("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised successor to the single-step snake mover. Owns the full snake state: body shift register, length, heading, growth and life/death FSM.
- Advances one cell per `tick`:
  - accepts buffered direction requests and rejects reversals;
  - grows on request;
  - detects wall and self collision, with an optional wrap-around playfield.
- Sits between the input/direction decoder and the VGA/board renderer, which reads the `body`, `len` and `head` outputs.

Parameters:
- MAX_LEN, 16: body slots.
- WIDTH, 32: playfield columns.
- HEIGHT, 24: playfield rows.
- POS_W, 10: cell-index width (pos = row*WIDTH + col). Must satisfy 2^POS_W >= WIDTH*HEIGHT.
- LEN_W, 5: length width. Must hold MAX_LEN.
- INIT_POS, 100: head cell after reset/restart.
- INIT_LEN, 3: length after reset. Requires 2 <= INIT_LEN <= MAX_LEN and INIT_POS%WIDTH >= INIT_LEN-1.
- WRAP, 0: 0 = walls kill, 1 = toroidal wrap.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. Synchronous, active-low.
- start, in, 1: IDLE->RUN; in DEAD, restart.
- tick, in, 1: single-cycle step strobe.
- dir_in, in, 2: requested heading. 00 left, 01 right, 10 up, 11 down.
- dir_valid, in, 1: dir_in qualifier.
- grow, in, 1: pulse; lengthen on next step.
- body, out, MAX_LEN*POS_W: slot i at [i*POS_W +: POS_W]. Slot 0 is the head.
- len, out, LEN_W: current length.
- head, out, POS_W: equals slot 0.
- alive, out, 1: high in RUN.
- dead, out, 1: high in DEAD.
- step_done, out, 1: one-cycle pulse after each executed step.

Behaviour:
- All outputs are registered.

Reset (rst_n=0 at a clk edge):
- State IDLE; cur_dir=01; pend_dir=01; grow_pend=0; len=INIT_LEN; step_done=0; alive=0; dead=0.
- Slot i = INIT_POS-i for i<INIT_LEN; other slots 0.
- Reset mid-step discards everything, including pending grow and direction.

FSM states and transitions:
- IDLE: start -> RUN. tick ignored. Simultaneous start+tick: start only, no step.
- RUN: a tick executes a step.
  - Collision -> DEAD.
  - Otherwise stay in RUN.
- DEAD: body, len and head frozen; tick ignored.
  - start reloads the reset layout, clears pending grow and direction, and enters RUN next cycle.

Direction handling:
- Opposite of d is d^2'b01.
- On dir_valid, latch dir_in into pend_dir unless dir_in == cur_dir^2'b01. A rejected request leaves pend_dir unchanged.
- The last accepted request before a step wins.
- If dir_valid coincides with tick, the same reversal test applies and an accepted dir_in is used for that step.
- At each step: cur_dir <= effective direction.

Step, computed combinationally and committed on the tick edge:
- nh = neighbour of head in the effective direction.
- Wall hit:
  - left at col 0;
  - right at col WIDTH-1;
  - up at row 0;
  - down at row HEIGHT-1.
- WRAP=0: a wall hit means collision.
- WRAP=1 wraps instead:
  - col 0 left -> col WIDTH-1;
  - row 0 up -> row HEIGHT-1, i.e. pos+(HEIGHT-1)*WIDTH;
  - same symmetrically for right and down.
- g = grow_pend | grow, and len<MAX_LEN.
- Self-collision: nh equals slot i for any i < len-1 (tail vacates). When g=1, compare i < len.
- On collision: state DEAD; body and len unchanged; step_done=1.
- Otherwise:
  - slot i <= slot i-1 for i >= 1; slot 0 <= nh;
  - len <= len+g;
  - step_done=1.

Grow:
- A grow pulse sets grow_pend, which is cleared at the next step.
- At len==MAX_LEN a grow saturates: no length change, flag cleared.
- Slots >= len are don't-care content; the renderer masks with len.

Latency:
- Outputs reflect a step on the cycle after the tick edge.
- step_done is high that same cycle only.

Decomposition:
- snake_pkg holds:
  - direction codes DIR_L/R/U/D;
  - FSM encoding ST_IDLE/RUN/DEAD;
  - an opposite-direction function;
  - the pos<->(row,col) helper.
- One natural sub-module: snake_next_head. It is combinational, takes pos, dir, WIDTH, HEIGHT, WRAP, and returns nh and wall_hit.

Test Plan (WIDTH=32, HEIGHT=24, INIT_POS=100, INIT_LEN=3 unless stated):
1. Reset, start, tick -> body 101,100,99; len=3; step_done pulses one cycle; alive=1.
2. After test 1: dir_valid with dir_in=00 (reversal), then tick -> rejected, head=102. Then dir_valid 11 and tick -> head=134.
3. Fresh run: grow pulse, then tick -> body 101,100,99,98; len=4. Grow on every tick until len=16, then one more grow -> len stays 16.
4. WRAP=0: start, then ticks with dir up -> heads 68, 36, 4, then dead=1 with head frozen at 4. WRAP=1, same stimulus: 4th up -> head=740, alive.
5. Self-collision, head h=102 after one right step, grown to len 5 (body h..h-4): steps down, left, up -> up target h-1 hits slot 3, dead=1. Same sequence with len 4 -> h-1 is the tail slot, so no death.
6. rst_n low for one cycle mid-RUN with grow pending -> IDLE; body 100,99,98; len=3; first post-start tick gives len 3.
